// File: rtl/mem_readback_checker_if.sv
// Read port between the readback checker and the memory under test.
// Address/strobe flow checker -> memory; data returns one cycle later.
// No handshake: one read per cycle, the memory must always accept.
interface mem_readback_checker_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data
   );
endinterface

// File: rtl/mem_readback_checker.sv
// Sweeps every memory address and checks each word against SEED+addr, counting mismatches.
// Latency: finish rises DEPTH+1 edges after start is sampled in IDLE.
// No backpressure: one read per cycle, start is ignored outside IDLE/DONE.
module mem_readback_checker #(
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   mem_readback_checker_if.master bus,
   output logic                  finish,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr
);

   localparam int                    DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  cmp_valid_q, cmp_valid_d;
   logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
   logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
   logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
   logic                  finish_q, finish_d;
   logic                  error_q, error_d;

   logic [DATA_WIDTH-1:0] exp_dat;
   logic                  mismatch;

   // Expected word for the address whose data is on the bus this cycle; data is
   // only looked at when cmp_valid is set, so garbage on an idle bus is harmless.
   always_comb begin
      exp_dat  = SEED + DATA_WIDTH'(cmp_addr_q);
      mismatch = cmp_valid_q && (bus.rd_data != exp_dat);
   end

   // Next state: compare-pipeline bookkeeping first, then the sweep sequencing,
   // so that a new sweep's clear overrides anything left from the previous one.
   always_comb begin
      state_d          = state_q;
      rd_en_d          = rd_en_q;
      rd_addr_d        = rd_addr_q;
      cmp_valid_d      = rd_en_q;
      cmp_addr_d       = rd_addr_q;
      err_count_d      = err_count_q;
      first_err_addr_d = first_err_addr_q;
      finish_d         = finish_q;
      error_d          = error_q;

      if (mismatch) begin
         err_count_d = err_count_q + (ADDR_WIDTH+1)'(1);
         if (err_count_q == '0) begin
            first_err_addr_d = cmp_addr_q;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d          = READ;
               rd_en_d          = 1'b1;
               rd_addr_d        = '0;
               err_count_d      = '0;
               first_err_addr_d = '0;
               error_d          = 1'b0;
               finish_d         = 1'b0;
            end
         end
         READ: begin
            // Address parks on the last word rather than wrapping to 0.
            if (rd_addr_q == LAST_ADDR) begin
               state_d = DRAIN;
               rd_en_d = 1'b0;
            end else begin
               rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            // The final word is compared on this edge, so error uses the updated count.
            state_d  = DONE;
            finish_d = 1'b1;
            error_d  = (err_count_d != '0);
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any sweep in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         rd_en_q          <= 1'b0;
         rd_addr_q        <= '0;
         cmp_valid_q      <= 1'b0;
         cmp_addr_q       <= '0;
         err_count_q      <= '0;
         first_err_addr_q <= '0;
         finish_q         <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         rd_en_q          <= rd_en_d;
         rd_addr_q        <= rd_addr_d;
         cmp_valid_q      <= cmp_valid_d;
         cmp_addr_q       <= cmp_addr_d;
         err_count_q      <= err_count_d;
         first_err_addr_q <= first_err_addr_d;
         finish_q         <= finish_d;
         error_q          <= error_d;
      end
   end

   assign bus.rd_en      = rd_en_q;
   assign bus.rd_addr    = rd_addr_q;
   assign finish         = finish_q;
   assign error          = error_q;
   assign err_count      = err_count_q;
   assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_mem_readback_checker.sv
// Bench for mem_readback_checker: a registered-read memory model plus a
// pattern-based reference that predicts error count and first failing address.
// Directed corruption cases followed by randomized corruption sweeps.
module tb_mem_readback_checker;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          start;
   logic          finish;
   logic          error;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err_addr;

   logic [DW-1:0] mem [DEPTH];

   int n_cmp;
   int n_bad;

   mem_readback_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_readback_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(8'hA5)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .bus            (bus.master),
      .finish         (finish),
      .error          (error),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered-read memory; drives junk on the bus when no read was issued.
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
      else           bus.rd_data <= DW'($urandom);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pattern(input int a);
      pattern = DW'(8'hA5 + a);
   endfunction

   task automatic load_clean();
      for (int a = 0; a < DEPTH; a++) mem[a] = pattern(a);
   endtask

   // Reference: scan the whole memory image against the pattern.
   task automatic model(output int cnt, output int first);
      cnt   = 0;
      first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         if (mem[a] != pattern(a)) begin
            if (cnt == 0) first = a;
            cnt++;
         end
      end
   endtask

   // Called at a negedge with the DUT idle; raises start and follows the sweep.
   task automatic do_sweep(input string name);
      int cycles, nrd, cnt, first;
      bit bad_seq, done;
      cycles  = 0;
      nrd     = 0;
      bad_seq = 0;
      done    = 0;
      start   = 1'b1;
      while (!done && cycles < 60) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            chk({name, "_fin_clr"}, 32'(finish), 0);
            chk({name, "_cnt_clr"}, 32'(err_count), 0);
         end
         if (bus.rd_en) begin
            if (bus.rd_addr != AW'(nrd)) bad_seq = 1;
            nrd++;
         end
         if (finish) done = 1;
      end
      model(cnt, first);
      chk({name, "_finish"},  32'(done), 1);
      chk({name, "_latency"}, 32'(cycles - 1), DEPTH + 1);
      chk({name, "_rd_cnt"},  32'(nrd), DEPTH);
      chk({name, "_rd_seq"},  32'(bad_seq), 0);
      chk({name, "_error"},   32'(error), 32'(cnt != 0));
      chk({name, "_errcnt"},  32'(err_count), 32'(cnt));
      chk({name, "_first"},   32'(first_err_addr), 32'(first));
   endtask

   task automatic go_idle();
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int  cnt, first;
      bit  hit, bad;
      n_cmp = 0;
      n_bad = 0;
      start = 1'b0;
      rst   = 1'b1;
      load_clean();
      repeat (2) @(negedge clk);
      chk("rst_rd_en",  32'(bus.rd_en), 0);
      chk("rst_addr",   32'(bus.rd_addr), 0);
      chk("rst_finish", 32'(finish), 0);
      chk("rst_error",  32'(error), 0);
      chk("rst_cnt",    32'(err_count), 0);
      chk("rst_first",  32'(first_err_addr), 0);
      rst = 1'b0;
      @(negedge clk);

      do_sweep("clean");
      go_idle();
      chk("idle_fin_held", 32'(finish), 1);

      load_clean();
      mem[5] = 8'h00;
      do_sweep("w5");
      go_idle();
      chk("idle_err_held", 32'(error), 1);

      load_clean();
      mem[3]  = 8'h00;
      mem[12] = 8'hFF;
      do_sweep("w3_12");
      go_idle();

      for (int a = 0; a < DEPTH; a++) mem[a] = ~pattern(a);
      do_sweep("all_inv");
      chk("all_inv_16", 32'(err_count), 16);
      go_idle();

      // Reset mid-sweep with an error already counted.
      load_clean();
      mem[2] = 8'h00;
      start  = 1'b1;
      hit    = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (bus.rd_en && bus.rd_addr == AW'(7)) hit = 1;
      end
      chk("mid_reach7", 32'(hit), 1);
      chk("mid_cnt_pre", 32'(err_count), 1);
      rst = 1'b1;
      #1;
      chk("mid_rd_en",  32'(bus.rd_en), 0);
      chk("mid_addr",   32'(bus.rd_addr), 0);
      chk("mid_finish", 32'(finish), 0);
      chk("mid_error",  32'(error), 0);
      chk("mid_cnt",    32'(err_count), 0);
      chk("mid_first",  32'(first_err_addr), 0);
      load_clean();
      @(negedge clk);
      rst = 1'b0;
      do_sweep("post_rst");

      // start held after finish: no second sweep.
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rd_en || !finish) bad = 1;
      end
      chk("hold_no_resweep", 32'(bad), 0);
      go_idle();
      mem[9] = 8'h3C;
      do_sweep("w9");
      go_idle();

      // Randomized corruption.
      for (int r = 0; r < 8; r++) begin
         int n;
         load_clean();
         n = $urandom_range(0, 5);
         for (int k = 0; k < n; k++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            mem[a] = mem[a] ^ DW'($urandom_range(1, 255));
         end
         do_sweep($sformatf("rnd%0d", r));
         go_idle();
      end

      model(cnt, first);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_readback_checker.md
Name: mem_readback_checker

Overview:
- Downstream verification stage for the memory under test.
- On start, sweeps every address of a registered-read memory and compares each returned word against a deterministic expected pattern.
- Counts mismatches and captures the first failing address.
- Reports finish/error in the same form the memory top level exposes to its bench.

Parameters:
ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH words checked per run.
DATA_WIDTH, 8, memory word width.
SEED, 8'hA5, pattern base; expected(addr) = (SEED + addr) mod 2**DATA_WIDTH, addr zero-extended.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  level request to begin a sweep; sampled only in IDLE.
rd_en  output  1  read strobe to memory, registered.
rd_addr  output  ADDR_WIDTH  read address to memory, registered.
rd_data  input  DATA_WIDTH  memory read data, valid exactly one cycle after the cycle rd_en/rd_addr are presented.
finish  output  1  sweep complete; held high in DONE.
error  output  1  high with finish when err_count != 0.
err_count  output  ADDR_WIDTH+1  number of mismatching words in the last/current sweep.
first_err_addr  output  ADDR_WIDTH  address of the first mismatch; 0 if none.

Behaviour:
- Reset (async, immediate): state=IDLE; rd_en=0, rd_addr=0, finish=0, error=0, err_count=0, first_err_addr=0; compare pipeline valid flag cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: if start=1 at an edge, go to READ. On that same edge: rd_en=1, rd_addr=0, err_count=0, first_err_addr=0, error=0, finish=0.
- READ: rd_en=1 each cycle; rd_addr increments by 1 per edge.
  - At the edge where rd_addr == DEPTH-1, go to DRAIN and set rd_en=0.
  - rd_addr holds DEPTH-1; no wrap to 0 during a sweep.
- Compare pipeline: one-cycle delayed copies of rd_en and rd_addr (cmp_valid, cmp_addr).
  - On each edge with cmp_valid=1, compare rd_data with expected(cmp_addr).
  - On mismatch, increment err_count.
  - If err_count was 0 before the increment, load first_err_addr = cmp_addr.
- DRAIN: one cycle; the last word is compared on the exiting edge; go to DONE.
- DONE: finish=1; error=(err_count!=0), registered on the DRAIN->DONE edge.
  - Stay in DONE while start=1.
  - When start=0, go to IDLE. finish and error stay high until the next sweep begins.
- Latency: start sampled at edge k -> rd_en high after edges k..k+15 (DEPTH=16) -> DRAIN after edge k+16 -> finish rises after edge k+17, i.e. DEPTH+1 edges after start sampled.
- One read issued per cycle; no back-pressure; no gaps.
- start deasserted during READ/DRAIN is ignored; the sweep completes.
- err_count cannot overflow: its maximum is DEPTH, which fits in ADDR_WIDTH+1 bits.
- Reset mid-sweep aborts immediately with all outputs at reset values; no partial result retained.
- rd_data is don't-care whenever cmp_valid=0 (X on the bus must not affect counters).

Test Plan:
- Memory preloaded with correct pattern (addr a holds 8'hA5+a), start=1 held -> rd_en high 16 cycles for addr 0..15; finish rises 17 edges after start sampled; error=0, err_count=0, first_err_addr=0.
- Word 5 corrupted to 8'h00 -> finish, error=1, err_count=1, first_err_addr=5.
- Words 3 and 12 corrupted -> err_count=2, first_err_addr=3 (not overwritten by 12).
- All 16 words inverted -> err_count=5'd16, error=1, no wrap.
- rst pulsed while rd_addr=7 -> rd_en, finish, error, counters zero immediately. Release rst with start high -> fresh sweep from addr 0 passes clean.
- start held high after finish -> no second sweep, finish stays 1. Drop start, then reassert with word 9 now corrupted -> counters cleared at start, second run reports err_count=1, first_err_addr=9.
